// File: rtl/inst_fetch_pkg.sv
// Shared word/opcode widths, opcode constants and fetch helpers for the inst_fetch slice.
// Optional branch prediction is enabled by defining BRANCH_PREDICT_EN.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define WORD 32
`define OP 6
`endif

package inst_fetch_pkg;
  localparam int WORD_W = `WORD;
  localparam int OP_W   = `OP;

  localparam logic [OP_W-1:0] OP_REGIMM = 6'd1;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE    = 6'd5;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'd6;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'd7;

  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  function automatic logic is_cond_branch(input logic [OP_W-1:0] op);
    return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

  // Word offset of a branch: sign-extended imm16 shifted to a byte offset.
  function automatic logic [WORD_W-1:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory, decode handshake and execute branch resolution.
interface inst_fetch_if;
  logic [`WORD-1:0] imem_addr;
  logic [`WORD-1:0] imem_data;
  logic             stall;
  logic             force_jump;
  logic [`WORD-1:0] next_pc;
  logic             ex_branch_valid;
  logic [`WORD-1:0] ex_branch_pc;
  logic             ex_branch_taken;
  logic             ex_mispredict;
  logic [`WORD-1:0] ex_branch_target;
  logic [`WORD-1:0] inst;
  logic [`WORD-1:0] if_pc;
  logic             if_branch_taken;

  modport master (
    output imem_addr, inst, if_pc, if_branch_taken,
    input  imem_data, stall, force_jump, next_pc,
           ex_branch_valid, ex_branch_pc, ex_branch_taken, ex_mispredict, ex_branch_target
  );

  modport slave (
    input  imem_addr, inst, if_pc, if_branch_taken,
    output imem_data, stall, force_jump, next_pc,
           ex_branch_valid, ex_branch_pc, ex_branch_taken, ex_mispredict, ex_branch_target
  );
endinterface

// File: rtl/inst_fetch_branch_history_table.sv
// 2-bit saturating branch counters: one async read port, one sync write port, reset to weakly not-taken.
module branch_history_table #(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [BHT_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  // Read sees the pre-update value when it collides with this cycle's write.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_taken && ctr_q[wr_idx] != 2'b11) begin
        ctr_d[wr_idx] = ctr_q[wr_idx] + 2'b01;
      end else if (!wr_taken && ctr_q[wr_idx] != 2'b00) begin
        ctr_d[wr_idx] = ctr_q[wr_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      ctr_q <= ctr_d;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// IF stage: PC register, next-PC priority mux, IF/ID register and branch-immediate adder.
// Define BRANCH_PREDICT_EN to enable BHT-based prediction; otherwise static not-taken.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BHT_BITS = 6
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic [WORD_W-1:0] if_pc_q, if_pc_d;
  logic [WORD_W-1:0] seq_pc;
  logic [WORD_W-1:0] fetch_pc;

  assign seq_pc = pc_q + 32'd4;

`ifdef BRANCH_PREDICT_EN
  logic       tk_q, tk_d;
  logic       pred;
  logic [1:0] hint_ctr;

  branch_history_table #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_q[BHT_BITS+1:2]),
    .rd_ctr   (hint_ctr),
    .wr_en    (bus.ex_branch_valid),
    .wr_idx   (bus.ex_branch_pc[BHT_BITS+1:2]),
    .wr_taken (bus.ex_branch_taken)
  );

  assign pred     = is_cond_branch(bus.imem_data[31:26]) && hint_ctr[1];
  assign fetch_pc = pred ? seq_pc + branch_offset(bus.imem_data[15:0]) : seq_pc;
  assign bus.if_branch_taken = tk_q;
`else
  assign fetch_pc = seq_pc;
  assign bus.if_branch_taken = 1'b0;
`endif

  assign bus.imem_addr = pc_q;
  assign bus.inst      = inst_q;
  assign bus.if_pc     = if_pc_q;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    if_pc_d = if_pc_q;
`ifdef BRANCH_PREDICT_EN
    tk_d    = tk_q;
`endif
    if (bus.ex_branch_valid && bus.ex_mispredict) begin
      pc_d    = bus.ex_branch_taken ? bus.ex_branch_target : bus.ex_branch_pc + 32'd4;
      inst_d  = NOP;
      if_pc_d = '0;
`ifdef BRANCH_PREDICT_EN
      tk_d    = 1'b0;
`endif
    end else if (!bus.stall) begin
      // next_pc is only trusted once the stall has dropped.
      if (bus.force_jump) begin
        pc_d    = bus.next_pc;
        inst_d  = NOP;
        if_pc_d = '0;
`ifdef BRANCH_PREDICT_EN
        tk_d    = 1'b0;
`endif
      end else begin
        pc_d    = fetch_pc;
        inst_d  = bus.imem_data;
        if_pc_d = pc_q;
`ifdef BRANCH_PREDICT_EN
        tk_d    = pred;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      if_pc_q <= '0;
`ifdef BRANCH_PREDICT_EN
      tk_q    <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      if_pc_q <= if_pc_d;
`ifdef BRANCH_PREDICT_EN
      tk_q    <= tk_d;
`endif
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic against a behavioural model.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if bus ();
  inst_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [1024];
  always_comb bus.imem_data = mem[bus.imem_addr[11:2]];

  // Reference model state
  logic [31:0] m_pc, m_inst, m_ifpc;
  logic        m_tk;
  int          m_bht [64];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_cond(input logic [5:0] op);
    return op == 6'd1 || op == 6'd4 || op == 6'd5 || op == 6'd6 || op == 6'd7;
  endfunction

  task automatic model_edge();
    logic [31:0]        word;
    logic signed [31:0] off;
    bit                 hint, pred;
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h0; m_ifpc = 32'h0; m_tk = 1'b0;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
    end else begin
      word = mem[m_pc[11:2]];
      hint = 1'b0;
`ifdef BRANCH_PREDICT_EN
      hint = (m_bht[m_pc[7:2]] >= 2);
`endif
      pred = is_cond(word[31:26]) && hint;
      off  = $signed(word[15:0]);
      if (bus.ex_branch_valid && bus.ex_mispredict) begin
        m_pc = bus.ex_branch_taken ? bus.ex_branch_target : bus.ex_branch_pc + 32'd4;
        m_inst = 32'h0; m_ifpc = 32'h0; m_tk = 1'b0;
      end else if (!bus.stall) begin
        if (bus.force_jump) begin
          m_pc = bus.next_pc;
          m_inst = 32'h0; m_ifpc = 32'h0; m_tk = 1'b0;
        end else begin
          m_inst = word; m_ifpc = m_pc; m_tk = pred;
          m_pc = pred ? m_pc + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
        end
      end
`ifdef BRANCH_PREDICT_EN
      if (bus.ex_branch_valid) begin
        if (bus.ex_branch_taken) m_bht[bus.ex_branch_pc[7:2]] = (m_bht[bus.ex_branch_pc[7:2]] == 3) ? 3 : m_bht[bus.ex_branch_pc[7:2]] + 1;
        else                     m_bht[bus.ex_branch_pc[7:2]] = (m_bht[bus.ex_branch_pc[7:2]] == 0) ? 0 : m_bht[bus.ex_branch_pc[7:2]] - 1;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("inst", bus.inst, m_inst);
    chk("if_pc", bus.if_pc, m_ifpc);
    chk("if_branch_taken", {31'd0, bus.if_branch_taken}, {31'd0, m_tk});
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.force_jump = 1'b0; bus.next_pc = 32'h0;
    bus.ex_branch_valid = 1'b0; bus.ex_branch_pc = 32'h0; bus.ex_branch_taken = 1'b0;
    bus.ex_mispredict = 1'b0; bus.ex_branch_target = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0020 + (32'(i) << 11);
    mem[8] = 32'h1000_0003;  // beq at 0x20, imm=3
    @(negedge clk);

    // Reset state and sequential fetch
    do_reset();
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_taken", {31'd0, bus.if_branch_taken}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_if_pc", bus.if_pc, 32'(k * 4));
      chk("seq_inst", bus.inst, 32'h0000_0020 + (32'(k) << 11));
      chk("seq_taken", {31'd0, bus.if_branch_taken}, 32'h0);
    end

    // Stall holds PC and IF/ID
    do_reset();
    tick(); tick();
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_addr", bus.imem_addr, 32'h8);
      chk("stall_if_pc", bus.if_pc, 32'h4);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_if_pc", bus.if_pc, 32'h8);
    chk("unstall_addr", bus.imem_addr, 32'hC);

    // force_jump, then force_jump under stall
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    bus.force_jump = 1'b1; bus.next_pc = 32'h40;
    tick();
    chk("jump_addr", bus.imem_addr, 32'h40);
    chk("jump_inst_nop", bus.inst, 32'h0);
    chk("jump_if_pc", bus.if_pc, 32'h0);
    bus.stall = 1'b1; bus.next_pc = 32'h80;
    tick();
    chk("jump_stall_addr", bus.imem_addr, 32'h40);
    bus.stall = 1'b0;
    tick();
    chk("jump_after_stall_addr", bus.imem_addr, 32'h80);

    // PC wrap
    bus.next_pc = 32'hFFFF_FFFC;
    tick();
    bus.force_jump = 1'b0;
    tick();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);

    // Train beq at 0x20 taken twice, then refetch it
    do_reset();
    bus.ex_branch_valid = 1'b1; bus.ex_branch_pc = 32'h20; bus.ex_branch_taken = 1'b1;
    tick(); tick();
    idle_inputs();
    bus.force_jump = 1'b1; bus.next_pc = 32'h20;
    tick();
    bus.force_jump = 1'b0;
    tick();
    chk("beq_if_pc", bus.if_pc, 32'h20);
    chk("beq_inst", bus.inst, 32'h1000_0003);
`ifdef BRANCH_PREDICT_EN
    chk("beq_pred_addr", bus.imem_addr, 32'h30);
    chk("beq_pred_taken", {31'd0, bus.if_branch_taken}, 32'h1);
`else
    chk("beq_pred_addr", bus.imem_addr, 32'h24);
    chk("beq_pred_taken", {31'd0, bus.if_branch_taken}, 32'h0);
`endif

    // Mispredict overrides stall
    bus.stall = 1'b1; bus.ex_branch_valid = 1'b1; bus.ex_mispredict = 1'b1;
    bus.ex_branch_taken = 1'b0; bus.ex_branch_pc = 32'h20; bus.ex_branch_target = 32'h30;
    tick();
    chk("mispred_addr", bus.imem_addr, 32'h24);
    chk("mispred_inst", bus.inst, 32'h0);
    chk("mispred_if_pc", bus.if_pc, 32'h0);
    chk("mispred_taken", {31'd0, bus.if_branch_taken}, 32'h0);
    idle_inputs();

    // Randomized traffic
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 4))
          0: w[31:26] = 6'd1;
          1: w[31:26] = 6'd4;
          2: w[31:26] = 6'd5;
          3: w[31:26] = 6'd6;
          default: w[31:26] = 6'd7;
        endcase
        w[15:0] = 16'($signed($urandom_range(0, 64)) - 32);
      end
      mem[i] = w;
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.stall = ($urandom_range(0, 99) < 15);
      bus.force_jump = ($urandom_range(0, 99) < 8);
      bus.next_pc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFF0 + {28'd0, 2'($urandom), 2'b00}
                                                 : {20'd0, 10'($urandom), 2'b00};
      bus.ex_branch_valid = ($urandom_range(0, 99) < 30);
      bus.ex_branch_pc = {20'd0, 10'($urandom), 2'b00};
      bus.ex_branch_taken = 1'($urandom);
      bus.ex_mispredict = ($urandom_range(0, 99) < 15);
      bus.ex_branch_target = {20'd0, 10'($urandom), 2'b00};
      tick();
    end
    rst = 1'b0;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
